// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS decode stage: data-path and
//               register-address defaults, opcode constants, the decode FSM
//               state type and an opcode-level register-write helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_depth = 5;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_VALID = 2'd2
    } dstate_t;

    // Opcodes whose result lands in a register. R-type with rd=0 is
    // filtered separately because it depends on the rd field.
    function automatic logic op_writes_reg(input logic [5:0] op);
        case (op)
            c_op_rtype, c_op_addi, c_op_andi,
            c_op_ori, c_op_lui, c_op_lw: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Purely combinational field decode of a MIPS instruction word.
//               Ports:
//                 i_instr    - 32-bit instruction word
//                 o_imm      - immediate (sign-extended, or upper-placed for lui)
//                 o_dest     - destination register (rd for R-type, else rt)
//                 o_opcode   - instr[31:26]
//                 o_funct    - instr[5:0]
//                 o_regwrite - instruction writes a register
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import mips_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic [31:0]      i_instr,
    output logic [WIDTH-1:0] o_imm,
    output logic [DEPTH-1:0] o_dest,
    output logic [5:0]       o_opcode,
    output logic [5:0]       o_funct,
    output logic             o_regwrite
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    // rs and shamt are not needed for the decoded bundle
    logic [9:0]  w_unused_fields;

    assign w_opcode        = i_instr[31:26];
    assign w_rt            = i_instr[20:16];
    assign w_rd            = i_instr[15:11];
    assign w_imm16         = i_instr[15:0];
    assign w_unused_fields = {i_instr[25:21], i_instr[10:6]};

    assign o_opcode = w_opcode;
    assign o_funct  = i_instr[5:0];

    always_comb begin
        o_imm = WIDTH'($signed(w_imm16));
        if (w_opcode == c_op_lui) begin
            o_imm = WIDTH'(w_imm16) << 16;
        end
    end

    assign o_dest = (w_opcode == c_op_rtype) ? DEPTH'(w_rd) : DEPTH'(w_rt);

    // An R-type aimed at $0 would be discarded by the register file anyway;
    // flag it as non-writing so later stages need not special-case it.
    assign o_regwrite = op_writes_reg(w_opcode) &&
                        !((w_opcode == c_op_rtype) && (w_rd == 5'd0));

endmodule : instr_decode
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : MIPS decode stage. Accepts an instruction, reads its two
//               source registers from an external register file, and hands a
//               decoded bundle to execute. Writebacks share the register-file
//               port and take priority over the read, with a starvation guard.
//               Ports:
//                 clk, rst_n             - clock, synchronous active-low reset
//                 in_valid/in_ready/instr - fetch handshake and instruction
//                 wb_valid/wb_ready/wb_addr/wb_data - writeback handshake
//                 rf_regwrite/rf_wr/rf_wd - register-file write port
//                 rf_rr1/rf_rr2, rf_rd1/rf_rd2 - register-file read port
//                 out_valid/out_ready    - execute handshake
//                 out_rs_val, out_rt_val, out_imm, out_dest,
//                 out_opcode, out_funct, out_regwrite - decoded bundle
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic             clk,
    input  logic             rst_n,
    // fetch handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    // writeback handshake
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [DEPTH-1:0] wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    // register file
    output logic             rf_regwrite,
    output logic [DEPTH-1:0] rf_rr1,
    output logic [DEPTH-1:0] rf_rr2,
    output logic [DEPTH-1:0] rf_wr,
    output logic [WIDTH-1:0] rf_wd,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    // execute handshake and bundle
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rs_val,
    output logic [WIDTH-1:0] out_rt_val,
    output logic [WIDTH-1:0] out_imm,
    output logic [DEPTH-1:0] out_dest,
    output logic [5:0]       out_opcode,
    output logic [5:0]       out_funct,
    output logic             out_regwrite
);

    // Consecutive writeback grants tolerated in READ before one is refused
    localparam logic [1:0] c_starve_limit = 2'd2;

    dstate_t          r_state;
    dstate_t          w_state_nxt;
    logic [31:0]      r_instr;
    logic [1:0]       r_wb_streak;
    logic [WIDTH-1:0] r_rs_val;
    logic [WIDTH-1:0] r_rt_val;
    logic [WIDTH-1:0] r_imm;
    logic [DEPTH-1:0] r_dest;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic             r_regwrite;

    logic             w_in_ready;
    logic             w_load_instr;
    logic             w_capture;
    logic             w_starve;
    logic             w_wb_ready;
    logic             w_wb_grant;
    logic [4:0]       w_rs_field;
    logic [4:0]       w_rt_field;

    logic [WIDTH-1:0] w_dec_imm;
    logic [DEPTH-1:0] w_dec_dest;
    logic [5:0]       w_dec_opcode;
    logic [5:0]       w_dec_funct;
    logic             w_dec_regwrite;

    assign w_rs_field = r_instr[25:21];
    assign w_rt_field = r_instr[20:16];

    // ------------------------------------------------------------------
    // Writeback arbitration: writes win the shared port, except that after
    // a run of grants in READ one cycle is refused so the read can finish.
    // ------------------------------------------------------------------
    assign w_starve   = (r_state == ST_READ) && (r_wb_streak == c_starve_limit);
    assign w_wb_ready = rst_n && !w_starve;
    assign w_wb_grant = wb_valid && w_wb_ready;

    assign wb_ready    = w_wb_ready;
    assign rf_regwrite = w_wb_grant && (wb_addr != '0);
    assign rf_wr       = w_wb_grant ? wb_addr : '0;
    assign rf_wd       = w_wb_grant ? wb_data : '0;

    assign rf_rr1 = DEPTH'(w_rs_field);
    assign rf_rr2 = DEPTH'(w_rt_field);

    // ------------------------------------------------------------------
    // Field decode of the held instruction
    // ------------------------------------------------------------------
    instr_decode #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_instr_decode (
        .i_instr    (r_instr),
        .o_imm      (w_dec_imm),
        .o_dest     (w_dec_dest),
        .o_opcode   (w_dec_opcode),
        .o_funct    (w_dec_funct),
        .o_regwrite (w_dec_regwrite)
    );

    // ------------------------------------------------------------------
    // FSM next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_load_instr = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = rst_n;
                if (in_valid) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = ST_READ;
                end
            end
            ST_READ: begin
                // Read data is only trustworthy when the port is not writing
                if (!w_wb_grant) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_ready) begin
                    // Bundle leaves this cycle, so a new instruction may enter
                    w_in_ready = rst_n;
                    if (in_valid) begin
                        w_load_instr = 1'b1;
                        w_state_nxt  = ST_READ;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready = w_in_ready;

    // ------------------------------------------------------------------
    // State and bundle registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_wb_streak <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_imm       <= '0;
            r_dest      <= '0;
            r_opcode    <= '0;
            r_funct     <= '0;
            r_regwrite  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load_instr) begin
                r_instr <= instr;
            end

            // Only back-to-back grants while reading count toward starvation
            if ((r_state == ST_READ) && w_wb_grant) begin
                r_wb_streak <= r_wb_streak + 2'd1;
            end else begin
                r_wb_streak <= '0;
            end

            if (w_capture) begin
                r_rs_val   <= (w_rs_field == 5'd0) ? '0 : rf_rd1;
                r_rt_val   <= (w_rt_field == 5'd0) ? '0 : rf_rd2;
                r_imm      <= w_dec_imm;
                r_dest     <= w_dec_dest;
                r_opcode   <= w_dec_opcode;
                r_funct    <= w_dec_funct;
                r_regwrite <= w_dec_regwrite;
            end
        end
    end

    assign out_valid    = (r_state == ST_VALID);
    assign out_rs_val   = r_rs_val;
    assign out_rt_val   = r_rt_val;
    assign out_imm      = r_imm;
    assign out_dest     = r_dest;
    assign out_opcode   = r_opcode;
    assign out_funct    = r_funct;
    assign out_regwrite = r_regwrite;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Holds a behavioural
//               register file for the DUT, a transaction-level reference
//               model compared every cycle, and directed scenarios with
//               hand-computed expectations followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    localparam int MP_IDLE  = 0;
    localparam int MP_READ  = 1;
    localparam int MP_VALID = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_regwrite;
    logic [4:0]  rf_rr1, rf_rr2, rf_wr;
    logic [31:0] rf_wd, rf_rd1, rf_rd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_val, out_rt_val, out_imm;
    logic [4:0]  out_dest;
    logic [5:0]  out_opcode, out_funct;
    logic        out_regwrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_regwrite  (rf_regwrite),
        .rf_rr1       (rf_rr1),
        .rf_rr2       (rf_rr2),
        .rf_wr        (rf_wr),
        .rf_wd        (rf_wd),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs_val   (out_rs_val),
        .out_rt_val   (out_rt_val),
        .out_imm      (out_imm),
        .out_dest     (out_dest),
        .out_opcode   (out_opcode),
        .out_funct    (out_funct),
        .out_regwrite (out_regwrite)
    );

    // ------------------------------------------------------------------
    // Register file seen by the DUT. Entry 0 holds junk and reads during a
    // write return junk, so the DUT must mask $0 and avoid write cycles.
    // ------------------------------------------------------------------
    logic [31:0] rf      [32];
    logic [31:0] rf_seed [32];
    bit          rf_ready;

    always @(posedge clk) begin
        if (!rf_ready) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_seed[i];
            rf_ready <= 1'b1;
        end else if (rf_regwrite) begin
            rf[rf_wr] <= rf_wd;
        end
    end

    assign rf_rd1 = rf_regwrite ? 32'hDEAD_BEEF : rf[rf_rr1];
    assign rf_rd2 = rf_regwrite ? 32'hDEAD_BEEF : rf[rf_rr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction life cycle and register contents
    // ------------------------------------------------------------------
    int          m_phase = MP_IDLE;
    int          m_streak = 0;
    bit          m_started;
    bit          m_cleared;
    logic [31:0] m_instr;
    logic [31:0] m_rs, m_rt, m_imm;
    logic [4:0]  m_dest;
    logic [5:0]  m_op, m_fn;
    logic        m_rw;
    logic [31:0] mregs [32];

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [15:0] h;
        h = ins[15:0];
        if (ins[31:26] == 6'h0F) return {h, 16'h0000};
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic ref_rw(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h00) return ins[15:11] != 5'd0;
        return op inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : mregs[r];
    endfunction

    always @(negedge clk) begin
        logic exp_wbr;
        logic grant;
        exp_wbr = rst_n && !(m_phase == MP_READ && m_streak == 2);
        grant   = wb_valid && exp_wbr;

        if (m_started) begin
            chk("wb_ready", {31'b0, wb_ready}, {31'b0, exp_wbr});
            chk("in_ready", {31'b0, in_ready},
                {31'b0, rst_n && (m_phase == MP_IDLE || (m_phase == MP_VALID && out_ready))});
            chk("rf_regwrite", {31'b0, rf_regwrite}, {31'b0, grant && (wb_addr != 5'd0)});
            if (grant && wb_addr != 5'd0) begin
                chk("rf_wr", {27'b0, rf_wr}, {27'b0, wb_addr});
                chk("rf_wd", rf_wd, wb_data);
            end
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == MP_VALID});
            if (m_phase == MP_READ) begin
                chk("rf_rr1", {27'b0, rf_rr1}, {27'b0, m_instr[25:21]});
                chk("rf_rr2", {27'b0, rf_rr2}, {27'b0, m_instr[20:16]});
            end
            if (m_phase == MP_VALID || m_cleared) begin
                chk("out_rs_val", out_rs_val, m_rs);
                chk("out_rt_val", out_rt_val, m_rt);
                chk("out_imm", out_imm, m_imm);
                chk("out_dest", {27'b0, out_dest}, {27'b0, m_dest});
                chk("out_opcode", {26'b0, out_opcode}, {26'b0, m_op});
                chk("out_funct", {26'b0, out_funct}, {26'b0, m_fn});
                chk("out_regwrite", {31'b0, out_regwrite}, {31'b0, m_rw});
            end
        end

        // advance to the state after the coming rising edge
        if (!rst_n) begin
            if (!m_started) begin
                for (int i = 0; i < 32; i++) mregs[i] = rf_seed[i];
            end
            m_started = 1'b1;
            m_phase   = MP_IDLE;
            m_streak  = 0;
            m_cleared = 1'b1;
            m_instr   = '0;
            m_rs = '0; m_rt = '0; m_imm = '0; m_dest = '0;
            m_op = '0; m_fn = '0; m_rw = 1'b0;
        end else if (m_started) begin
            case (m_phase)
                MP_IDLE: begin
                    if (in_valid) begin
                        m_instr = instr; m_phase = MP_READ; m_streak = 0;
                    end
                end
                MP_READ: begin
                    if (grant) begin
                        m_streak++;
                    end else begin
                        m_rs   = ref_read(m_instr[25:21]);
                        m_rt   = ref_read(m_instr[20:16]);
                        m_imm  = ref_imm(m_instr);
                        m_dest = (m_instr[31:26] == 6'h00) ? m_instr[15:11] : m_instr[20:16];
                        m_op   = m_instr[31:26];
                        m_fn   = m_instr[5:0];
                        m_rw   = ref_rw(m_instr);
                        m_cleared = 1'b0;
                        m_phase   = MP_VALID;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            m_instr = instr; m_phase = MP_READ; m_streak = 0;
                        end else begin
                            m_phase = MP_IDLE;
                        end
                    end
                end
            endcase
            if (grant && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [8];
        logic [5:0] op;
        logic [31:0] r;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04};
        op  = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
        r   = $urandom;
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), r[10:0]};
    endfunction

    initial begin
        bit burst;
        for (int i = 0; i < 32; i++) rf_seed[i] = $urandom;
        rf_seed[0] = 32'hBAD0_0000;

        rst_n = 1'b0; in_valid = 1'b1; instr = 32'h00A01820;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555_5555; out_ready = 1'b1;
        repeat (3) tick();
        chk("reset in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset wb_ready", {31'b0, wb_ready}, 32'd0);
        chk("reset rf_regwrite", {31'b0, rf_regwrite}, 32'd0);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // add $3,$5,$0 after writing $5
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_valid = 1'b0; in_valid = 1'b1; instr = 32'h00A01820;
        tick();                                    // accepted at this edge
        in_valid = 1'b0;
        chk("add N+1 out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("add N+2 out_valid", {31'b0, out_valid}, 32'd1);
        chk("add rs", out_rs_val, 32'h1234);
        chk("add rt", out_rt_val, 32'h0);
        chk("add dest", {27'b0, out_dest}, 32'd3);
        chk("add regwrite", {31'b0, out_regwrite}, 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // addi $2,$7,-1 with a colliding writeback to $7
        in_valid = 1'b1; instr = 32'h20E2FFFF;
        tick();
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
        tick();
        wb_valid = 1'b0;
        chk("addi stall out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("addi out_valid", {31'b0, out_valid}, 32'd1);
        chk("addi rs", out_rs_val, 32'hAA);
        chk("addi imm", out_imm, 32'hFFFF_FFFF);
        chk("addi dest", {27'b0, out_dest}, 32'd2);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // lw $4,4($7) with writeback held high through READ
        in_valid = 1'b1; instr = 32'h8CE40004;
        tick();
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h100;
        #1 chk("starve grant1", {31'b0, wb_ready}, 32'd1);
        tick();
        wb_data = 32'h200;
        #1 chk("starve grant2", {31'b0, wb_ready}, 32'd1);
        tick();
        chk("starve refuse", {31'b0, wb_ready}, 32'd0);
        chk("starve out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("starve done out_valid", {31'b0, out_valid}, 32'd1);
        chk("starve wb_ready back", {31'b0, wb_ready}, 32'd1);
        chk("lw rs", out_rs_val, 32'h200);
        chk("lw imm", out_imm, 32'h4);
        chk("lw dest", {27'b0, out_dest}, 32'd4);
        wb_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;

        // writeback to $0 then read $0
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1 chk("wb0 wb_ready", {31'b0, wb_ready}, 32'd1);
        chk("wb0 rf_regwrite", {31'b0, rf_regwrite}, 32'd0);
        tick();
        wb_valid = 1'b0; in_valid = 1'b1; instr = 32'h00003025;  // or $6,$0,$0
        tick();
        in_valid = 1'b0;
        tick();
        chk("r0 rs", out_rs_val, 32'h0);
        chk("r0 rt", out_rt_val, 32'h0);
        chk("r0 dest", {27'b0, out_dest}, 32'd6);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // ori $8,$3,0xF0 held for 5 cycles, then back-to-back lui $9,0x1234
        in_valid = 1'b1; instr = 32'h346800F0;
        tick();
        instr = 32'h3C091234;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold out_valid", {31'b0, out_valid}, 32'd1);
            chk("hold imm", out_imm, 32'h0000_00F0);
            chk("hold dest", {27'b0, out_dest}, 32'd8);
            chk("hold rs", out_rs_val, mregs[3]);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("lui out_valid", {31'b0, out_valid}, 32'd1);
        chk("lui imm", out_imm, 32'h1234_0000);
        chk("lui dest", {27'b0, out_dest}, 32'd9);
        chk("lui opcode", {26'b0, out_opcode}, 32'h0F);

        // reset during VALID
        rst_n = 1'b0;
        tick();
        chk("rstv out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstv rs", out_rs_val, 32'h0);
        chk("rstv imm", out_imm, 32'h0);
        chk("rstv dest", {27'b0, out_dest}, 32'd0);
        chk("rstv opcode", {26'b0, out_opcode}, 32'd0);
        chk("rstv regwrite", {31'b0, out_regwrite}, 32'd0);
        rst_n = 1'b1;
        #1 chk("rstv idle in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // randomized traffic
        burst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) burst = ~burst;
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            instr     = rand_instr();
            wb_valid  = ($urandom_range(0, 9) < (burst ? 9 : 3));
            wb_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end

        rst_n = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
